// File: rtl/trigger_link_pkg.sv
`default_nettype none
// ============================================================================
// Module      : trigger_link_pkg
// Description : Shared state encodings, default timing constants and small
//               helpers for the trigger link bring-up controller.
// Revision    : 1.0 - initial release
// ============================================================================
package trigger_link_pkg;

    // Number of GTX links served by one controller
    localparam int N_LINKS = 4;

    // Width of the shared dwell/timeout counter and the exported state
    localparam int CNT_W   = 12;
    localparam int STATE_W = 3;
    localparam int RETRY_W = 8;

    // Default hold / timeout lengths in ref_clk cycles
    localparam int DEF_PLL_RST_CYCLES  = 16;
    localparam int DEF_MMCM_RST_CYCLES = 8;
    localparam int DEF_GTX_RST_CYCLES  = 8;
    localparam int DEF_LOCK_TIMEOUT    = 4096;

    // Bring-up sequencer states; the numeric values are visible on the state port
    typedef enum logic [STATE_W-1:0] {
        ST_PLL_RST   = 3'd0,
        ST_PLL_WAIT  = 3'd1,
        ST_MMCM_RST  = 3'd2,
        ST_MMCM_WAIT = 3'd3,
        ST_GTX_RST   = 3'd4,
        ST_GTX_WAIT  = 3'd5,
        ST_READY     = 3'd6
    } link_state_e;

    // Saturating increment for the restart counter
    function automatic logic [RETRY_W-1:0] sat_inc(input logic [RETRY_W-1:0] v);
        return (v == {RETRY_W{1'b1}}) ? v : v + {{(RETRY_W-1){1'b0}}, 1'b1};
    endfunction

    // Output decodes: each reset is held through its own stage and every earlier one
    function automatic logic dec_txpll_rst(input link_state_e s);
        return (s == ST_PLL_RST);
    endfunction

    function automatic logic dec_mmcm_rst(input link_state_e s);
        return (s == ST_PLL_RST) || (s == ST_PLL_WAIT) || (s == ST_MMCM_RST);
    endfunction

    function automatic logic dec_gtx_rst(input link_state_e s);
        return (s != ST_GTX_WAIT) && (s != ST_READY);
    endfunction

    function automatic logic dec_link_en(input link_state_e s);
        return (s == ST_READY);
    endfunction

endpackage : trigger_link_pkg
`default_nettype wire

// File: rtl/trigger_link_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : trigger_link_ctrl_if
// Description : Status/control bundle between the link bring-up controller and
//               the GTX/MMCM clocking fabric it sequences.
// Revision    : 1.0 - initial release
// ============================================================================
interface trigger_link_ctrl_if;
    import trigger_link_pkg::*;

    // Status from the clocking fabric (lock/done are asynchronous to ref_clk)
    logic [N_LINKS-1:0] tx_pll_locked;
    logic               mmcm_locked;
    logic [N_LINKS-1:0] tx_reset_done;
    logic               force_resync;

    // Resets and status produced by the controller
    logic               txpll_rst;
    logic               mmcm_rst;
    logic               gtx_rst;
    logic               link_en;
    logic [STATE_W-1:0] state;
    logic [RETRY_W-1:0] retry_cnt;
    logic               lock_lost;

    // Controller side: drives the resets, observes lock/done
    modport master (
        input  tx_pll_locked,
        input  mmcm_locked,
        input  tx_reset_done,
        input  force_resync,
        output txpll_rst,
        output mmcm_rst,
        output gtx_rst,
        output link_en,
        output state,
        output retry_cnt,
        output lock_lost
    );

    // Fabric side: reports lock/done, receives the resets
    modport slave (
        output tx_pll_locked,
        output mmcm_locked,
        output tx_reset_done,
        output force_resync,
        input  txpll_rst,
        input  mmcm_rst,
        input  gtx_rst,
        input  link_en,
        input  state,
        input  retry_cnt,
        input  lock_lost
    );

endinterface : trigger_link_ctrl_if
`default_nettype wire

// File: rtl/trigger_link_sync.sv
`default_nettype none
// ============================================================================
// Module      : trigger_link_sync
// Description : Two-flop synchronizer bringing one asynchronous status bit
//               into the ref_clk domain.
// Revision    : 1.0 - initial release
// ============================================================================
module trigger_link_sync (
    input  wire logic clk,
    input  wire logic rst_n,
    input  wire logic d_i,
    output logic      q_o
);

    logic meta_q;
    logic sync_q;

    // First flop may go metastable; second flop gives it a full cycle to resolve
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule : trigger_link_sync
`default_nettype wire

// File: rtl/trigger_link_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : trigger_link_ctrl
// Description : Trigger link bring-up sequencer. Steps the GTX TX PLLs, the
//               user-clock MMCM and the GTX TX datapath out of reset in order,
//               watches the locks, restarts on loss/timeout and only enables
//               the links once everything is up.
// Revision    : 1.0 - initial release
// ============================================================================
module trigger_link_ctrl
    import trigger_link_pkg::*;
#(
    parameter int PLL_RST_CYCLES  = DEF_PLL_RST_CYCLES,
    parameter int MMCM_RST_CYCLES = DEF_MMCM_RST_CYCLES,
    parameter int GTX_RST_CYCLES  = DEF_GTX_RST_CYCLES,
    parameter int LOCK_TIMEOUT    = DEF_LOCK_TIMEOUT
) (
    input  wire logic            ref_clk,
    input  wire logic            reset_n,
    trigger_link_ctrl_if.master  bus
);

    // Last counter value of each timed state (the state is held for N cycles)
    localparam logic [CNT_W-1:0] PLL_RST_LAST  = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] MMCM_RST_LAST = CNT_W'(MMCM_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] GTX_RST_LAST  = CNT_W'(GTX_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST  = CNT_W'(LOCK_TIMEOUT - 1);

    // Asynchronous status bits, bundled so one generate loop synchronizes them all
    localparam int N_SYNC = 2 * N_LINKS + 1;

    logic [N_SYNC-1:0]  async_in;
    logic [N_SYNC-1:0]  sync_out;
    logic [N_LINKS-1:0] pll_locked_s;
    logic               mmcm_locked_s;
    logic [N_LINKS-1:0] reset_done_s;

    assign async_in = {bus.tx_reset_done, bus.mmcm_locked, bus.tx_pll_locked};

    generate
        for (genvar i = 0; i < N_SYNC; i++) begin : g_sync
            trigger_link_sync u_sync (
                .clk   (ref_clk),
                .rst_n (reset_n),
                .d_i   (async_in[i]),
                .q_o   (sync_out[i])
            );
        end
    endgenerate

    assign pll_locked_s  = sync_out[N_LINKS-1:0];
    assign mmcm_locked_s = sync_out[N_LINKS];
    assign reset_done_s  = sync_out[N_SYNC-1:N_LINKS+1];

    // Registered state and bookkeeping
    link_state_e        state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [RETRY_W-1:0] retry_q;
    logic               lock_lost_q;
    logic               txpll_rst_q;
    logic               mmcm_rst_q;
    logic               gtx_rst_q;
    logic               link_en_q;

    // Next-state decision outputs
    link_state_e        state_d;
    logic               leave_d;      // any transition, including forced re-entry of PLL_RST
    logic               restart_d;    // automatic restart that counts as a retry
    logic               set_lost_d;
    logic               clr_lost_d;

    logic               pll_all;
    logic               pll_lost;
    logic               mmcm_lost;
    logic               timed_out;

    assign pll_all   = &pll_locked_s;
    assign timed_out = (cnt_q == TIMEOUT_LAST);

    // Lock monitoring only applies once the stage depending on that lock has started
    assign pll_lost  = !pll_all &&
                       ((state_q == ST_MMCM_WAIT) || (state_q == ST_GTX_RST) ||
                        (state_q == ST_GTX_WAIT)  || (state_q == ST_READY));
    assign mmcm_lost = !mmcm_locked_s &&
                       ((state_q == ST_GTX_RST) || (state_q == ST_GTX_WAIT) ||
                        (state_q == ST_READY));

    // Next-state selection: forced resync, then lock loss, then normal progress,
    // and within a WAIT state the advance condition beats the timeout
    always_comb begin
        state_d    = state_q;
        leave_d    = 1'b0;
        restart_d  = 1'b0;
        set_lost_d = 1'b0;
        clr_lost_d = 1'b0;

        if (bus.force_resync) begin
            state_d    = ST_PLL_RST;
            leave_d    = 1'b1;
            clr_lost_d = 1'b1;
        end else if (pll_lost || mmcm_lost) begin
            state_d    = ST_PLL_RST;
            leave_d    = 1'b1;
            restart_d  = 1'b1;
            set_lost_d = (state_q == ST_READY);
        end else begin
            case (state_q)
                ST_PLL_RST: begin
                    if (cnt_q == PLL_RST_LAST) begin
                        state_d = ST_PLL_WAIT;
                        leave_d = 1'b1;
                    end
                end
                ST_PLL_WAIT: begin
                    if (pll_all) begin
                        state_d = ST_MMCM_RST;
                        leave_d = 1'b1;
                    end else if (timed_out) begin
                        state_d   = ST_PLL_RST;
                        leave_d   = 1'b1;
                        restart_d = 1'b1;
                    end
                end
                ST_MMCM_RST: begin
                    if (cnt_q == MMCM_RST_LAST) begin
                        state_d = ST_MMCM_WAIT;
                        leave_d = 1'b1;
                    end
                end
                ST_MMCM_WAIT: begin
                    if (mmcm_locked_s) begin
                        state_d = ST_GTX_RST;
                        leave_d = 1'b1;
                    end else if (timed_out) begin
                        state_d   = ST_PLL_RST;
                        leave_d   = 1'b1;
                        restart_d = 1'b1;
                    end
                end
                ST_GTX_RST: begin
                    if (cnt_q == GTX_RST_LAST) begin
                        state_d = ST_GTX_WAIT;
                        leave_d = 1'b1;
                    end
                end
                ST_GTX_WAIT: begin
                    if (&reset_done_s) begin
                        state_d = ST_READY;
                        leave_d = 1'b1;
                    end else if (timed_out) begin
                        state_d   = ST_PLL_RST;
                        leave_d   = 1'b1;
                        restart_d = 1'b1;
                    end
                end
                ST_READY: begin
                    state_d = ST_READY;
                end
                default: begin
                    state_d = ST_PLL_RST;
                    leave_d = 1'b1;
                end
            endcase
        end
    end

    // Sequencer registers; outputs decode the next state so they move with state
    always_ff @(posedge ref_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_PLL_RST;
            cnt_q       <= '0;
            retry_q     <= '0;
            lock_lost_q <= 1'b0;
            txpll_rst_q <= 1'b1;
            mmcm_rst_q  <= 1'b1;
            gtx_rst_q   <= 1'b1;
            link_en_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= leave_d ? '0 : cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};

            if (restart_d) begin
                retry_q <= sat_inc(retry_q);
            end

            if (clr_lost_d) begin
                lock_lost_q <= 1'b0;
            end else if (set_lost_d) begin
                lock_lost_q <= 1'b1;
            end

            txpll_rst_q <= dec_txpll_rst(state_d);
            mmcm_rst_q  <= dec_mmcm_rst(state_d);
            gtx_rst_q   <= dec_gtx_rst(state_d);
            link_en_q   <= dec_link_en(state_d);
        end
    end

    assign bus.txpll_rst = txpll_rst_q;
    assign bus.mmcm_rst  = mmcm_rst_q;
    assign bus.gtx_rst   = gtx_rst_q;
    assign bus.link_en   = link_en_q;
    assign bus.state     = state_q;
    assign bus.retry_cnt = retry_q;
    assign bus.lock_lost = lock_lost_q;

endmodule : trigger_link_ctrl
`default_nettype wire

// File: tb/tb_trigger_link_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_trigger_link_ctrl
// Description : Scoreboard bench for trigger_link_ctrl. A phase/time reference
//               model predicts every change of the visible output vector and
//               the cycle it happens on; a monitor checks the DUT against it.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_trigger_link_ctrl;

    localparam int PLL_RST_CYCLES  = 16;
    localparam int MMCM_RST_CYCLES = 8;
    localparam int GTX_RST_CYCLES  = 8;
    localparam int LOCK_TIMEOUT    = 4096;

    logic ref_clk;
    logic reset_n;

    trigger_link_ctrl_if bus ();

    trigger_link_ctrl #(
        .PLL_RST_CYCLES  (PLL_RST_CYCLES),
        .MMCM_RST_CYCLES (MMCM_RST_CYCLES),
        .GTX_RST_CYCLES  (GTX_RST_CYCLES),
        .LOCK_TIMEOUT    (LOCK_TIMEOUT)
    ) dut (
        .ref_clk (ref_clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial begin
        ref_clk = 1'b0;
        forever #5 ref_clk = ~ref_clk;
    end

    int n_assert = 0;
    int n_fail   = 0;

    typedef struct {
        int          cyc;
        logic [15:0] vec;
    } exp_t;

    exp_t sb[$];

    // Visible output vector: {state, txpll_rst, mmcm_rst, gtx_rst, link_en, retry_cnt, lock_lost}
    function automatic logic [15:0] exp_vec(input int p, input int r, input bit ll);
        logic [2:0] s;
        s = 3'(p);
        return {s, (p == 0), (p <= 2), (p <= 4), (p == 6), 8'(r), ll};
    endfunction

    function automatic logic [15:0] dut_vec();
        return {bus.state, bus.txpll_rst, bus.mmcm_rst, bus.gtx_rst, bus.link_en,
                bus.retry_cnt, bus.lock_lost};
    endfunction

    function automatic int hold_len(input int p);
        if (p == 0) return PLL_RST_CYCLES;
        if (p == 2) return MMCM_RST_CYCLES;
        return GTX_RST_CYCLES;
    endfunction

    // Reference model: phase index, time spent in phase, and inputs seen two edges late
    int          cyc;
    int          m_p, m_t, m_retry, m_nxt;
    bit          m_ll;
    logic [3:0]  pll_d1, pll_d2, done_d1, done_d2;
    logic        mm_d1, mm_d2;
    bit          s_pll, s_mm, s_done, m_adv;
    logic [15:0] m_prev, m_cur;

    always @(posedge ref_clk or negedge reset_n) begin
        if (!reset_n) begin
            m_p = 0; m_t = 0; m_retry = 0; m_ll = 0;
            pll_d1 = '0; pll_d2 = '0; done_d1 = '0; done_d2 = '0;
            mm_d1 = 1'b0; mm_d2 = 1'b0;
            sb.delete();
            m_prev = exp_vec(0, 0, 0);
        end else begin
            cyc++;
            s_pll  = (pll_d2 == 4'hF);
            s_mm   = mm_d2;
            s_done = (done_d2 == 4'hF);
            m_nxt  = -1;
            if (bus.force_resync) begin
                m_nxt = 0;
                m_ll  = 0;
            end else if ((m_p >= 3 && !s_pll) || (m_p >= 4 && !s_mm)) begin
                if (m_p == 6) m_ll = 1;
                m_retry = (m_retry < 255) ? m_retry + 1 : 255;
                m_nxt   = 0;
            end else if (m_p == 0 || m_p == 2 || m_p == 4) begin
                if (m_t + 1 == hold_len(m_p)) m_nxt = m_p + 1;
            end else if (m_p != 6) begin
                m_adv = (m_p == 1) ? s_pll : (m_p == 3) ? s_mm : s_done;
                if (m_adv) begin
                    m_nxt = m_p + 1;
                end else if (m_t + 1 == LOCK_TIMEOUT) begin
                    m_retry = (m_retry < 255) ? m_retry + 1 : 255;
                    m_nxt   = 0;
                end
            end
            if (m_nxt >= 0) begin
                m_p = m_nxt;
                m_t = 0;
            end else begin
                m_t++;
            end
            pll_d2 = pll_d1;  pll_d1 = bus.tx_pll_locked;
            mm_d2  = mm_d1;   mm_d1  = bus.mmcm_locked;
            done_d2 = done_d1; done_d1 = bus.tx_reset_done;
            m_cur = exp_vec(m_p, m_retry, m_ll);
            if (m_cur != m_prev) sb.push_back('{cyc: cyc, vec: m_cur});
            m_prev = m_cur;
        end
    end

    // Monitor: every change of the DUT output vector must match the next prediction
    logic [15:0] prev_obs, obs;
    exp_t        e;

    always @(negedge ref_clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_obs = exp_vec(0, 0, 0);
        end else begin
            obs = dut_vec();
            if (obs !== prev_obs) begin
                n_assert++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_unexpected cyc=%0d got=%h required no change from %h", cyc, obs, prev_obs);
                end else begin
                    e = sb.pop_front();
                    if (e.cyc != cyc || e.vec !== obs) begin
                        n_fail++;
                        $display("FAIL sb_change got=%h@%0d required=%h@%0d", obs, cyc, e.vec, e.cyc);
                    end
                end
            end
            while (sb.size() > 0 && sb[0].cyc <= cyc) begin
                e = sb.pop_front();
                n_assert++;
                n_fail++;
                $display("FAIL sb_missed got=%h@%0d required=%h@%0d", obs, cyc, e.vec, e.cyc);
            end
            prev_obs = obs;
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
        n_assert++;
        if (got !== req) begin
            n_fail++;
            $display("FAIL %s got=%0h required=%0h", name, got, req);
        end
    endtask

    task automatic wait_state(input logic [2:0] s, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge ref_clk);
            if (bus.state == s) return;
        end
        n_assert++;
        n_fail++;
        $display("FAIL wait_state got=%0d required=%0d within %0d cycles", bus.state, s, budget);
    endtask

    task automatic pulse_resync();
        @(negedge ref_clk);
        bus.force_resync = 1'b1;
        @(negedge ref_clk);
        bus.force_resync = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_state"},     32'(bus.state),     32'd0);
        check({tag, "_txpll_rst"}, 32'(bus.txpll_rst), 32'd1);
        check({tag, "_mmcm_rst"},  32'(bus.mmcm_rst),  32'd1);
        check({tag, "_gtx_rst"},   32'(bus.gtx_rst),   32'd1);
        check({tag, "_link_en"},   32'(bus.link_en),   32'd0);
        check({tag, "_retry_cnt"}, 32'(bus.retry_cnt), 32'd0);
        check({tag, "_lock_lost"}, 32'(bus.lock_lost), 32'd0);
    endtask

    int  k_txpll, k_link, k_drop;
    bit  seen_drop;

    initial begin
        cyc = 0;
        reset_n = 1'b1;
        bus.tx_pll_locked = 4'hF;
        bus.mmcm_locked   = 1'b1;
        bus.tx_reset_done = 4'hF;
        bus.force_resync  = 1'b0;

        // Asynchronous reset before any clock edge
        #1 reset_n = 1'b0;
        #1 check_reset_outputs("por");
        @(negedge ref_clk);
        #2 reset_n = 1'b1;

        // Clean bring-up: measure txpll_rst hold and link_en arrival
        k_txpll = -1;
        k_link  = -1;
        for (int k = 1; k <= 60 && k_link < 0; k++) begin
            @(negedge ref_clk);
            if (k_txpll < 0 && !bus.txpll_rst) k_txpll = k;
            if (k_link  < 0 && bus.link_en)    k_link  = k;
        end
        check("txpll_rst_hold", 32'(k_txpll), 32'(PLL_RST_CYCLES));
        check("link_en_window", 32'(k_link >= 35 && k_link <= 39), 32'd1);
        check("bringup_retry", 32'(bus.retry_cnt), 32'd0);

        // Lock loss in READY: mmcm_locked low for three cycles
        repeat (5) @(negedge ref_clk);
        bus.mmcm_locked = 1'b0;
        seen_drop = 0;
        k_drop = 0;
        for (int j = 1; j <= 3; j++) begin
            @(negedge ref_clk);
            if (j == 3) bus.mmcm_locked = 1'b1;
            if (!seen_drop && !bus.link_en) begin
                seen_drop = 1;
                k_drop = j;
            end
        end
        check("lockloss_link_en_drop", 32'(seen_drop), 32'd1);
        check("lockloss_lock_lost", 32'(bus.lock_lost), 32'd1);
        check("lockloss_retry", 32'(bus.retry_cnt), 32'd1);

        // Rerun stalls in GTX_WAIT; force_resync there clears lock_lost without a retry
        bus.tx_reset_done = 4'h0;
        wait_state(3'd5, 300);
        repeat (4) @(negedge ref_clk);
        check("gtxwait_lock_lost_set", 32'(bus.lock_lost), 32'd1);
        bus.force_resync = 1'b1;
        @(negedge ref_clk);
        bus.force_resync = 1'b0;
        check("resync_state", 32'(bus.state), 32'd0);
        check("resync_lock_lost", 32'(bus.lock_lost), 32'd0);
        check("resync_retry", 32'(bus.retry_cnt), 32'd1);

        // Done arrives exactly when the GTX_WAIT counter reaches its last value
        wait_state(3'd5, 300);
        repeat (4093) @(negedge ref_clk);
        bus.tx_reset_done = 4'hF;
        repeat (2) @(negedge ref_clk);
        check("edge_still_gtx_wait", 32'(bus.state), 32'd5);
        @(negedge ref_clk);
        check("edge_advance_ready", 32'(bus.state), 32'd6);
        check("edge_retry", 32'(bus.retry_cnt), 32'd1);

        // One PLL never locks: lock-loss restart, then repeated PLL_WAIT timeouts
        bus.tx_pll_locked = 4'b1011;
        repeat (2 * (PLL_RST_CYCLES + LOCK_TIMEOUT) + 40) @(negedge ref_clk);
        check("timeout_retry", 32'(bus.retry_cnt), 32'd4);
        check("timeout_txpll_rst", 32'(bus.state == 3'd0 || bus.state == 3'd1), 32'd1);
        bus.tx_pll_locked = 4'hF;

        // Randomized lock/done glitches and occasional resync requests
        for (int i = 0; i < 4000; i++) begin
            @(negedge ref_clk);
            if ($urandom_range(0, 49) == 0)
                bus.tx_pll_locked = ($urandom_range(0, 1) == 1) ? 4'hF : 4'($urandom);
            if ($urandom_range(0, 49) == 0)
                bus.mmcm_locked = 1'($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 29) == 0)
                bus.tx_reset_done = ($urandom_range(0, 1) == 1) ? 4'hF : 4'($urandom);
            bus.force_resync = ($urandom_range(0, 399) == 0);
        end
        bus.force_resync  = 1'b0;
        bus.tx_pll_locked = 4'hF;
        bus.tx_reset_done = 4'hF;

        // Drive retry_cnt into saturation with quick PLL drops in MMCM_WAIT
        bus.mmcm_locked = 1'b0;
        pulse_resync();
        for (int n = 0; n < 265; n++) begin
            wait_state(3'd3, 100);
            bus.tx_pll_locked = 4'b1101;
            repeat (3) @(negedge ref_clk);
            bus.tx_pll_locked = 4'hF;
        end
        check("retry_saturated", 32'(bus.retry_cnt), 32'd255);

        // Back to READY, then reset asynchronously mid-cycle
        bus.mmcm_locked = 1'b1;
        pulse_resync();
        wait_state(3'd6, 100);
        repeat (5) @(negedge ref_clk);
        check("sb_drained", 32'(sb.size()), 32'd0);
        @(posedge ref_clk);
        #2 reset_n = 1'b0;
        #1 check_reset_outputs("async_rst");
        repeat (3) @(negedge ref_clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule : tb_trigger_link_ctrl
`default_nettype wire

// File: doc/trigger_link_ctrl.md
TRIGGER_LINK_CTRL -- requirements
Module: trigger_link_ctrl

Interface
REQ-001 Parameter PLL_RST_CYCLES, default 16, cycles txpll_rst is held high in PLL_RST.
REQ-002 Parameter MMCM_RST_CYCLES, default 8, cycles held in MMCM_RST.
REQ-003 Parameter GTX_RST_CYCLES, default 8, cycles held in GTX_RST.
REQ-004 Parameter LOCK_TIMEOUT, default 4096, maximum cycles spent in any WAIT state.
REQ-005 One clock; reset is asynchronous and active-low.
REQ-006 ref_clk  in  1  40 MHz QPLL clock; all logic on its rising edge.
REQ-007 reset_n  in  1  asynchronous active-low reset.
REQ-008 tx_pll_locked  in  4  per-link GTX TX PLL lock; asynchronous to ref_clk.
REQ-009 mmcm_locked  in  1  user-clock MMCM lock; asynchronous.
REQ-010 tx_reset_done  in  4  per-link GTX TX reset done; asynchronous.
REQ-011 force_resync  in  1  synchronous single-cycle request to restart the sequence.
REQ-012 txpll_rst  out  1  GTX TX PLL reset to all four links.
REQ-013 mmcm_rst  out  1  MMCM reset.
REQ-014 gtx_rst  out  1  GTX TX reset to all four links.
REQ-015 link_en  out  1  high only when links are usable; gates cluster data onto the links.
REQ-016 state  out  3  current state encoding.
REQ-017 retry_cnt  out  8  saturating count of automatic restarts.
REQ-018 lock_lost  out  1  sticky flag: lock dropped while READY.

Function
REQ-019 Lock/done inputs SHALL pass through 2-flop synchronizers; decisions use synchronized values only (2-cycle input latency).
REQ-020 States SHALL be PLL_RST=0, PLL_WAIT=1, MMCM_RST=2, MMCM_WAIT=3, GTX_RST=4, GTX_WAIT=5, READY=6.
REQ-021 One shared 12-bit cycle counter SHALL clear on every state transition.
REQ-022 PLL_RST -> PLL_WAIT after exactly PLL_RST_CYCLES cycles; MMCM_RST -> MMCM_WAIT after MMCM_RST_CYCLES; GTX_RST -> GTX_WAIT after GTX_RST_CYCLES.
REQ-023 PLL_WAIT -> MMCM_RST when all 4 tx_pll_locked high; MMCM_WAIT -> GTX_RST when mmcm_locked high; GTX_WAIT -> READY when all 4 tx_reset_done high.
REQ-024 In MMCM_WAIT, GTX_RST, GTX_WAIT or READY, any tx_pll_locked low SHALL go to PLL_RST; in GTX_RST, GTX_WAIT or READY, mmcm_locked low SHALL go to PLL_RST.
REQ-025 A WAIT state whose counter reaches LOCK_TIMEOUT-1 without its advance condition SHALL go to PLL_RST (timeout).
REQ-026 Advance condition and timeout in the same cycle: advance wins.
REQ-027 Every lock-loss or timeout restart SHALL increment retry_cnt, saturating at 255.
REQ-028 Lock loss while in READY SHALL also set lock_lost.
REQ-029 force_resync SHALL take priority over all transitions: go to PLL_RST, clear lock_lost, and not increment retry_cnt.
REQ-030 Outputs SHALL be registered, decoded from next state, so they change on the same edge as state: txpll_rst=1 only in PLL_RST; mmcm_rst=1 in states 0-2; gtx_rst=1 in states 0-4; link_en=1 only in READY.

Reset
REQ-031 On reset_n low: state=PLL_RST, counter=0, txpll_rst=1, mmcm_rst=1, gtx_rst=1, link_en=0, retry_cnt=0, lock_lost=0, synchronizers=0.
REQ-032 After reset_n deasserts, the sequence SHALL start from PLL_RST with a full PLL_RST_CYCLES hold; reset mid-sequence SHALL drop link_en immediately (asynchronously).

Structure
REQ-033 State encodings and default timing constants SHALL live in the shared package trigger_link_pkg.
REQ-034 The 2-flop synchronizer SHALL be the sub-module trigger_link_sync, instantiated per input bit.

Verification
REQ-035 Locks and done tied high, reset released -> txpll_rst high 16 cycles, link_en high 16+1+2+8+1+8+1 cycles ±2 synchronizer cycles after reset; no retries.
REQ-036 tx_pll_locked[2] held low -> timeout after 4096 cycles in PLL_WAIT, retry_cnt=1, txpll_rst reasserted; repeats until saturation at 255.
REQ-037 In READY, mmcm_locked pulses low for 3 cycles -> link_en low within 3 cycles, lock_lost=1, retry_cnt+1, full sequence reruns to READY.
REQ-038 force_resync in GTX_WAIT with lock_lost=1 -> state=0 next cycle, lock_lost=0, retry_cnt unchanged.
REQ-039 tx_reset_done all high on the same cycle the GTX_WAIT counter reaches 4095 -> state=READY, retry_cnt unchanged.
REQ-040 reset_n asserted in READY -> link_en=0 without a ref_clk edge; all outputs at REQ-031 values.
